hazard_unit_v2: RTL

Parametrised successor to the pipeline hazard logic of the 5-stage MIPS core; it merges forwarding control and stall control into one block. It adds decode-stage branch-operand forwarding, branch-compare stalls and taken-branch/jump flush. It also adds a cycle-counting busy timer for a multi-cycle multiply/divide unit (MDU) and a saturating stall-cycle performance counter. It sits beside the datapath, consuming stage register addresses and control bits and driving forward selects, stalls and flushes.

---
 rtl/mips_pipe_pkg.sv | 14 +
 rtl/mdu_busy_timer.sv | 29 ++
 rtl/hazard_unit_v2.sv | 118 +++++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core: forward-select
// encodings and register-address constants.
package mips_pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/mdu_busy_timer.sv
// Busy timer for the multi-cycle multiply/divide unit: busy for LAT-1 cycles
// after a start; a start while busy restarts the countdown.
module mdu_busy_timer #(
  parameter int LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy
);

  localparam int CW = $clog2(LAT);
  localparam logic [CW-1:0] LOAD = CW'(LAT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= LOAD;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign busy = (r_count != '0);

endmodule

// File: rtl/hazard_unit_v2.sv
// Forwarding, stall and flush control for the 5-stage MIPS pipeline, with a
// saturating stall counter. Define HAZARD_MDU_EN to add the MDU busy timer.
module hazard_unit_v2
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MDU_LAT    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RsD,
  input  logic [REG_ADDR_W-1:0] RtD,
  input  logic [REG_ADDR_W-1:0] RsE,
  input  logic [REG_ADDR_W-1:0] RtE,
  input  logic [REG_ADDR_W-1:0] WriteRegE,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegW,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  MemtoRegM,
  input  logic                  BranchD,
  input  logic                  JumpD,
  input  logic                  PCSrcD,
  input  logic                  MduStartE,
  input  logic                  MduUseD,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  ForwardAD,
  output logic                  ForwardBD,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  MduBusy,
  output logic [CNT_W-1:0]      StallCnt
);

  localparam logic [REG_ADDR_W-1:0] W_ZERO = REG_ADDR_W'(REG_ZERO);

  logic w_rse_m, w_rse_w, w_rte_m, w_rte_w;
  logic w_rsd_m, w_rtd_m;
  logic w_lw_stall, w_br_stall, w_mdu_stall, w_stall;
  logic w_e_hits_d, w_m_hits_d;
  logic w_mdu_busy;
  logic [CNT_W-1:0] r_stall_cnt;

  // Register 0 is hardwired, so a source of 0 never takes part in a hazard.
  assign w_rse_m = (RsE != W_ZERO) && RegWriteM && (RsE == WriteRegM);
  assign w_rse_w = (RsE != W_ZERO) && RegWriteW && (RsE == WriteRegW);
  assign w_rte_m = (RtE != W_ZERO) && RegWriteM && (RtE == WriteRegM);
  assign w_rte_w = (RtE != W_ZERO) && RegWriteW && (RtE == WriteRegW);
  assign w_rsd_m = (RsD != W_ZERO) && RegWriteM && (RsD == WriteRegM);
  assign w_rtd_m = (RtD != W_ZERO) && RegWriteM && (RtD == WriteRegM);

  always_comb begin
    ForwardAE = FWD_NONE;
    if (w_rse_m)      ForwardAE = FWD_MEM;
    else if (w_rse_w) ForwardAE = FWD_WB;
  end

  always_comb begin
    ForwardBE = FWD_NONE;
    if (w_rte_m)      ForwardBE = FWD_MEM;
    else if (w_rte_w) ForwardBE = FWD_WB;
  end

  assign ForwardAD = w_rsd_m;
  assign ForwardBD = w_rtd_m;

  assign w_lw_stall = MemtoRegE && (RtE != W_ZERO) && ((RtE == RsD) || (RtE == RtD));

  // A branch compares in D, so any producer still in E, or a load in M, must drain first.
  assign w_e_hits_d = RegWriteE && (WriteRegE != W_ZERO) &&
                      ((WriteRegE == RsD) || (WriteRegE == RtD));
  assign w_m_hits_d = MemtoRegM && (WriteRegM != W_ZERO) &&
                      ((WriteRegM == RsD) || (WriteRegM == RtD));
  assign w_br_stall = BranchD && (w_e_hits_d || w_m_hits_d);

`ifdef HAZARD_MDU_EN
  mdu_busy_timer #(
    .LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk   (clk),
    .reset (reset),
    .start (MduStartE),
    .busy  (w_mdu_busy)
  );
  assign w_mdu_stall = w_mdu_busy && MduUseD;
`else
  localparam int MDU_LAT_UNUSED = MDU_LAT;
  logic w_mdu_unused;
  assign w_mdu_unused = MduStartE ^ MduUseD;
  assign w_mdu_busy   = 1'b0;
  assign w_mdu_stall  = 1'b0;
`endif

  assign w_stall = w_lw_stall | w_br_stall | w_mdu_stall;

  assign StallF  = w_stall;
  assign StallD  = w_stall;
  assign FlushE  = w_stall;
  assign FlushD  = (PCSrcD | JumpD) && !w_stall;
  assign MduBusy = w_mdu_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign StallCnt = r_stall_cnt;

endmodule
